vram_stream: RTL and testbench

Parametrised single-clock video RAM with a byte-lane CPU port and a burst streaming read port for scanout/blitter use. The CPU side reads and writes one word per cycle with per-byte enables. The stream side takes a start address and length, then delivers consecutive words over a valid/ready interface with backpressure. It sits between the CPU bus decoder and the video/scanout logic, replacing fixed-width 16-bit dual-port framebuffers.

---
 rtl/vram_pkg.sv | 17 +
 rtl/vram_stream_if.sv | 42 ++++
 rtl/vram_skid_fifo.sv | 67 ++++++
 rtl/vram_stream.sv | 137 +++++++++++++
 tb/tb_vram_stream.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared definitions for the vram_stream block.
//   st_state_e : burst engine states (IDLE / RUN / DRAIN)
//   bytes_of() : number of 8-bit lanes in a data word
package vram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } st_state_e;

  // Byte-lane count for a word width that is a multiple of 8.
  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/vram_stream_if.sv
// vram_stream_if: CPU port and burst stream port of vram_stream.
//   CPU    : cpu_we, cpu_addr, cpu_din, cpu_be -> cpu_dout
//   Burst  : st_start, st_addr, st_len -> st_busy, st_done
//   Stream : out_valid, out_data, out_last <-> out_ready
// slave = the RAM, master = the bus decoder / video consumer side.
interface vram_stream_if
  import vram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 8
);
  localparam int BYTES = bytes_of(DATA_W);

  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic [BYTES-1:0]  cpu_be;
  logic [DATA_W-1:0] cpu_dout;

  logic              st_start;
  logic [ADDR_W-1:0] st_addr;
  logic [LEN_W-1:0]  st_len;
  logic              st_busy;
  logic              st_done;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  cpu_we, cpu_addr, cpu_din, cpu_be, st_start, st_addr, st_len, out_ready,
    output cpu_dout, st_busy, st_done, out_valid, out_data, out_last
  );

  modport master (
    output cpu_we, cpu_addr, cpu_din, cpu_be, st_start, st_addr, st_len, out_ready,
    input  cpu_dout, st_busy, st_done, out_valid, out_data, out_last
  );

endinterface

// File: rtl/vram_skid_fifo.sv
// vram_skid_fifo: 2-entry valid/ready FIFO feeding the stream output.
//   clk_i, reset_i         : clock, synchronous active-high reset
//   push_i, push_data_i    : write side (caller guarantees no push when full)
//   pop_i                  : consumer handshake (ignored when empty)
//   valid_o, data_o        : head entry, held stable until popped
//   count_o                : occupancy 0..2
module vram_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         pop_s;

  assign pop_s   = pop_i && (count_q != 2'd0);
  assign valid_o = (count_q != 2'd0);
  assign data_o  = head_q;
  assign count_o = count_q;

  // Head/tail shift register; the head only changes on a pop or on a push into an empty FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case ({push_i, pop_s})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q  <= push_data_i;
            count_q <= 2'd1;
          end else if (count_q == 2'd1) begin
            tail_q  <= push_data_i;
            count_q <= 2'd2;
          end
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_q <= push_data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data_i;
          end
        end
        default: begin
          count_q <= count_q;
        end
      endcase
    end
  end

endmodule

// File: rtl/vram_stream.sv
// vram_stream: single-clock video RAM with a byte-lane CPU port and a
// burst streaming read port.
//   clk_i   : clock, all logic on the rising edge
//   reset_i : synchronous active-high reset (memory contents survive it)
//   bus     : vram_stream_if.slave -- CPU read/write port, burst request
//             (st_start/st_addr/st_len, st_busy/st_done) and the
//             valid/ready output stream (out_data/out_last).
module vram_stream
  import vram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14,
  parameter int LEN_W  = 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  vram_stream_if.slave   bus
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;

  st_state_e         state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              busy_q;
  logic              done_q;

  logic              fifo_valid_s;
  logic [DATA_W:0]   fifo_data_s;
  logic [1:0]        fifo_count_s;
  logic              pop_s;
  logic              issue_s;
  logic              last_s;
  logic              drain_empty_s;

  wire  [DATA_W-1:0] cpu_rd_s;
  wire  [DATA_W-1:0] st_rd_s;

  assign pop_s  = fifo_valid_s && bus.out_ready;
  assign last_s = (remaining_q == LEN_W'(1));
  // Occupancy after this cycle's pop; a read is issued only if it will still fit.
  assign issue_s       = (state_q == ST_RUN) && ((fifo_count_s - {1'b0, pop_s}) < 2'd2);
  assign drain_empty_s = ((fifo_count_s - {1'b0, pop_s}) == 2'd0);

  // One byte-wide array per lane so each byte enable maps onto its own write port.
  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] dout_q;

    // Lane write, gated by its byte enable.
    always_ff @(posedge clk_i) begin
      if (bus.cpu_we && bus.cpu_be[i]) begin
        mem_q[bus.cpu_addr] <= bus.cpu_din[8*i +: 8];
      end
    end

    // Registered CPU read; returns the pre-write word on a same-address write.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        dout_q <= 8'h00;
      end else begin
        dout_q <= mem_q[bus.cpu_addr];
      end
    end

    assign cpu_rd_s[8*i +: 8] = dout_q;
    // Stream read is captured straight into the FIFO at the issue edge, so it
    // sees the memory before any CPU write landing on that same edge.
    assign st_rd_s[8*i +: 8]  = mem_q[rd_addr_q];
  end

  // Burst engine: accept request, issue reads while the FIFO has room, then drain.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.st_start && (bus.st_len != '0)) begin
            rd_addr_q   <= bus.st_addr;
            remaining_q <= bus.st_len;
            busy_q      <= 1'b1;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue_s) begin
            // Address wraps naturally past the top of memory.
            rd_addr_q   <= rd_addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
            if (last_s) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_empty_s) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  vram_skid_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (issue_s),
    .push_data_i ({last_s, st_rd_s}),
    .pop_i       (pop_s),
    .valid_o     (fifo_valid_s),
    .data_o      (fifo_data_s),
    .count_o     (fifo_count_s)
  );

  assign bus.cpu_dout  = cpu_rd_s;
  assign bus.st_busy   = busy_q;
  assign bus.st_done   = done_q;
  assign bus.out_valid = fifo_valid_s;
  assign bus.out_data  = fifo_data_s[DATA_W-1:0];
  assign bus.out_last  = fifo_data_s[DATA_W];

endmodule

// File: tb/tb_vram_stream.sv
// Self-checking bench for vram_stream: a flat array models the RAM and each
// burst's expected stream is a queue of words read from that array.
module tb_vram_stream;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;

  vram_stream_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  vram_stream #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] ref_mem [DEPTH];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] be);
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    bus.cpu_be   = be;
    tick();
    for (int i = 0; i < 2; i++) begin
      if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
    end
    bus.cpu_we = 1'b0;
    bus.cpu_be = 2'b00;
  endtask

  task automatic cpu_read_chk(input string tag, input logic [13:0] a);
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = a;
    tick();
    chk_eq(tag, 32'(bus.cpu_dout), 32'(ref_mem[a]));
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1 repeating; 2: random.
  // Returns the cycle (relative to the request cycle 0) of the first out_valid
  // and of the st_done pulse.
  task automatic run_burst(input logic [13:0] a, input int len, input int mode,
                           input bit poke_start, output int first_valid, output int done_cyc);
    logic [15:0] exp_q[$];
    bit          got_all;
    bit          held;
    logic [15:0] held_data;
    logic        held_last;
    logic        rdy;
    int          bound;
    first_valid = -1;
    done_cyc    = -1;
    got_all     = 1'b0;
    held        = 1'b0;
    held_data   = 16'h0000;
    held_last   = 1'b0;
    bound       = 8 * len + 20;
    for (int k = 0; k < len; k++) exp_q.push_back(ref_mem[14'(a + 14'(k))]);
    bus.st_start  = 1'b1;
    bus.st_addr   = a;
    bus.st_len    = 8'(len);
    bus.out_ready = 1'b1;
    tick();
    for (int k = 1; k < bound; k++) begin
      bus.st_start = 1'b0;
      if (k == 1) chk_eq("busy_rise", 32'(bus.st_busy), 32'd1);
      if (held) begin
        chk_eq("hold_valid", 32'(bus.out_valid), 32'd1);
        chk_eq("hold_data", 32'(bus.out_data), 32'(held_data));
        chk_eq("hold_last", 32'(bus.out_last), 32'(held_last));
      end
      if (got_all) begin
        chk_eq("done_pulse", 32'(bus.st_done), 32'd1);
        chk_eq("busy_fall", 32'(bus.st_busy), 32'd0);
        chk_eq("idle_valid", 32'(bus.out_valid), 32'd0);
        done_cyc = k;
        break;
      end
      chk_eq("no_early_done", 32'(bus.st_done), 32'd0);
      if (bus.out_valid && first_valid < 0) first_valid = k;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (((k - 1) % 4) == 0) || (((k - 1) % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = rdy;
      if (poke_start && (k == 2 || k == 3)) begin
        bus.st_start = 1'b1;
        bus.st_addr  = a + 14'd100;
        bus.st_len   = 8'd3;
      end
      held      = bus.out_valid && !rdy;
      held_data = bus.out_data;
      held_last = bus.out_last;
      if (bus.out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk_eq("extra_word", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          chk_eq("stream_data", 32'(bus.out_data), 32'(exp_q[0]));
          chk_eq("stream_last", 32'(bus.out_last), 32'(exp_q.size() == 1));
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) got_all = 1'b1;
        end
      end
      tick();
    end
    bus.st_start = 1'b0;
    if (done_cyc < 0) chk_eq("burst_timeout", 32'(exp_q.size()), 32'hFFFF_FFFF);
  endtask

  initial begin
    int fv;
    int dc;
    logic [13:0] a;
    logic [15:0] d;
    logic [1:0]  be;
    logic [15:0] old;

    reset         = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 14'd0;
    bus.cpu_din   = 16'h0000;
    bus.cpu_be    = 2'b00;
    bus.st_start  = 1'b0;
    bus.st_addr   = 14'd0;
    bus.st_len    = 8'd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    repeat (3) tick();

    // Reset values
    chk_eq("rst_cpu_dout", 32'(bus.cpu_dout), 32'd0);
    chk_eq("rst_busy", 32'(bus.st_busy), 32'd0);
    chk_eq("rst_done", 32'(bus.st_done), 32'd0);
    chk_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("rst_last", 32'(bus.out_last), 32'd0);
    chk_eq("rst_data", 32'(bus.out_data), 32'd0);
    reset = 1'b0;
    tick();

    // Preload: mem[k]=k at the bottom, random words at the top
    for (int k = 0; k < 64; k++) cpu_write(14'(k), 16'(k), 2'b11);
    for (int k = 16'h3FF0; k < DEPTH; k++) cpu_write(14'(k), 16'($urandom), 2'b11);

    // Byte lanes
    cpu_write(14'd5, 16'h1234, 2'b11);
    cpu_write(14'd5, 16'hAB00, 2'b10);
    bus.cpu_addr = 14'd5;
    tick();
    chk_eq("lane_merge", 32'(bus.cpu_dout), 32'h0000_AB34);
    cpu_write(14'd7, 16'h0000, 2'b11);
    bus.cpu_we = 1'b1; bus.cpu_addr = 14'd7; bus.cpu_din = 16'hFFFF; bus.cpu_be = 2'b11;
    tick();
    chk_eq("rbw_old", 32'(bus.cpu_dout), 32'h0000_0000);
    ref_mem[7] = 16'hFFFF;
    bus.cpu_we = 1'b0; bus.cpu_be = 2'b00;
    tick();
    chk_eq("rbw_new", 32'(bus.cpu_dout), 32'h0000_FFFF);
    cpu_write(14'd9, 16'h5A5A, 2'b00);
    cpu_read_chk("be_zero_noop", 14'd9);

    // Directed burst at 10, len 4, ready high, with a start poked during RUN
    run_burst(14'd10, 4, 0, 1'b1, fv, dc);
    chk_eq("burst_first_valid", 32'(fv), 32'd2);
    chk_eq("burst_done_cyc", 32'(dc), 32'd6);
    // Back-to-back: new request in the st_done cycle
    run_burst(14'd20, 3, 0, 1'b0, fv, dc);
    chk_eq("b2b_first_valid", 32'(fv), 32'd2);
    chk_eq("b2b_done_cyc", 32'(dc), 32'd5);

    // Backpressure 1,0,0,1,...
    run_burst(14'd30, 6, 1, 1'b0, fv, dc);
    // Wrap past the top of memory
    run_burst(14'h3FFE, 4, 0, 1'b0, fv, dc);
    chk_eq("wrap_done_cyc", 32'(dc), 32'd6);

    // Zero-length request is ignored
    bus.st_start = 1'b1; bus.st_addr = 14'd3; bus.st_len = 8'd0;
    tick();
    bus.st_start = 1'b0;
    chk_eq("len0_busy", 32'(bus.st_busy), 32'd0);
    chk_eq("len0_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk_eq("len0_done", 32'(bus.st_done), 32'd0);
    chk_eq("len0_busy2", 32'(bus.st_busy), 32'd0);

    // Reset mid-burst
    bus.st_start = 1'b1; bus.st_addr = 14'd40; bus.st_len = 8'd8; bus.out_ready = 1'b1;
    tick();
    bus.st_start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_eq("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("mid_rst_busy", 32'(bus.st_busy), 32'd0);
    chk_eq("mid_rst_done", 32'(bus.st_done), 32'd0);
    chk_eq("mid_rst_data", 32'(bus.out_data), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_eq("post_rst_no_done", 32'(bus.st_done), 32'd0);
      chk_eq("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    for (int k = 40; k < 48; k++) cpu_read_chk("mem_kept", 14'(k));
    cpu_read_chk("mem_kept_top", 14'h3FFF);

    // Random CPU traffic
    for (int n = 0; n < 200; n++) begin
      a  = 14'($urandom_range(0, 63));
      d  = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      bus.cpu_we   = 1'($urandom_range(0, 1));
      bus.cpu_addr = a;
      bus.cpu_din  = d;
      bus.cpu_be   = be;
      old = ref_mem[a];
      tick();
      chk_eq("cpu_rand_rd", 32'(bus.cpu_dout), 32'(old));
      if (bus.cpu_we) begin
        for (int i = 0; i < 2; i++) begin
          if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
        end
      end
    end
    bus.cpu_we = 1'b0; bus.cpu_be = 2'b00;
    tick();

    // Random bursts, random backpressure
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 1) == 1) a = 14'($urandom_range(0, 55));
      else a = 14'h3FF8 + 14'($urandom_range(0, 7));
      run_burst(a, int'($urandom_range(1, 8)), 2, 1'b0, fv, dc);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
